maze_rom_arbiter: RTL

Arbitrates the single-port maze ROM (2K × 16) between two requesters: the display renderer (pixel-deadline port, D) and the maze controller (move/collision lookups, C). Each requester issues reads through a req/gnt handshake, and read data is returned on its own port tagged with a valid pulse. The block sits between the pixel-clock requesters and the ROM instance. It replaces a direct ROM hookup, so both consumers can share one BRAM port.

---
 rtl/maze_pkg.sv | 19 +
 rtl/rom_read_tracker.sv | 66 ++++++
 rtl/maze_rom_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze ROM datapath: ROM geometry,
// read-owner tags and arbitration states.
package maze_pkg;

    localparam int MAZE_ROM_ADDR_W = 11;
    localparam int MAZE_ROM_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CTRL = 2'd2
    } rom_owner_t;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_C = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rom_read_tracker.sv
// Follows each issued ROM read with an owner tag and, when the tag leaves the
// pipeline, captures the ROM word into the owning port's registered outputs.
module rom_read_tracker
    import maze_pkg::*;
#(
    parameter int DATA_W = MAZE_ROM_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        owner_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o
);

    rom_owner_t        tag_q [DEPTH];
    rom_owner_t        tag_d [DEPTH];
    logic              d_rvalid_q, d_rvalid_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;

    always_comb begin
        tag_d[0] = rom_owner_t'(owner_i);
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The last tag stage lines up with the cycle the ROM word is valid.
    always_comb begin
        d_rvalid_d = (tag_q[DEPTH-1] == OWN_DISP);
        c_rvalid_d = (tag_q[DEPTH-1] == OWN_CTRL);
        d_rdata_d  = d_rvalid_d ? rom_data_i : d_rdata_q;
        c_rdata_d  = c_rvalid_d ? rom_data_i : c_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= OWN_NONE;
            end
            d_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            c_rdata_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
            d_rvalid_q <= d_rvalid_d;
            c_rvalid_q <= c_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            c_rdata_q  <= c_rdata_d;
        end
    end

    assign d_rvalid_o = d_rvalid_q;
    assign d_rdata_o  = d_rdata_q;
    assign c_rvalid_o = c_rvalid_q;
    assign c_rdata_o  = c_rdata_q;

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares one maze ROM port between the display renderer (D) and maze controller (C).
// Define MAZE_ROM_AGING_EN to let a long-waiting controller win one grant over D.
//
// state  | meaning
// PRIO_D | display has priority; controller wait cycles are counted
// PRIO_C | controller promoted for exactly one handshake
module maze_rom_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W      = MAZE_ROM_ADDR_W,
    parameter int DATA_W      = MAZE_ROM_DATA_W,
    parameter int ROM_LATENCY = 1,
    parameter int AGE_MAX     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    input  logic              i_c_req,
    input  logic [ADDR_W-1:0] i_c_addr,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data
);

    logic              promote;
    logic              d_hs;
    logic              c_hs;
    logic [1:0]        issue_owner;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    assign o_d_gnt = i_d_req & ~promote;
    assign o_c_gnt = i_c_req & (~i_d_req | promote);
    assign d_hs    = i_d_req & o_d_gnt;
    assign c_hs    = i_c_req & o_c_gnt;

`ifdef MAZE_ROM_AGING_EN
    localparam int CNT_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [CNT_W-1:0] AGE_LIMIT = CNT_W'(AGE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PRIO_D;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        promote    = (state_q == PRIO_C);

        if (!i_c_req || c_hs) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != AGE_LIMIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        case (state_q)
            PRIO_D: begin
                if (i_c_req && (wait_cnt_q == AGE_LIMIT)) begin
                    state_d = PRIO_C;
                end
            end
            PRIO_C: begin
                // Leave after a single controller grant so D stalls at most once.
                if (c_hs || !i_c_req) begin
                    state_d = PRIO_D;
                end
            end
            default: state_d = PRIO_D;
        endcase
    end
`else
    logic unused_age_max;

    assign promote        = 1'b0;
    assign unused_age_max = ^AGE_MAX;
`endif

    always_comb begin
        rom_en_d    = d_hs | c_hs;
        rom_addr_d  = rom_addr_q;
        issue_owner = OWN_NONE;
        if (d_hs) begin
            rom_addr_d  = i_d_addr;
            issue_owner = OWN_DISP;
        end else if (c_hs) begin
            rom_addr_d  = i_c_addr;
            issue_owner = OWN_CTRL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign o_rom_en   = rom_en_q;
    assign o_rom_addr = rom_addr_q;

    rom_read_tracker #(
        .DATA_W (DATA_W),
        .DEPTH  (ROM_LATENCY + 1)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .owner_i    (issue_owner),
        .rom_data_i (i_rom_data),
        .d_rvalid_o (o_d_rvalid),
        .d_rdata_o  (o_d_rdata),
        .c_rvalid_o (o_c_rvalid),
        .c_rdata_o  (o_c_rdata)
    );

endmodule
